// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-level request stream in, instruction-memory write port
// and program status out. DEPTH sizes the word counter.
interface instr_encoder_if #(
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [3:0]    req_cond;
  logic [3:0]    req_cmd;
  logic          req_imm;
  logic          req_s;
  logic          req_load;
  logic [3:0]    req_rn;
  logic [3:0]    req_rd;
  logic [23:0]   req_imm24;
  logic          seal;
  logic          clear;
  logic          im_we;
  logic [31:0]   im_addr;
  logic [31:0]   im_wdata;
  logic [CW-1:0] word_count;
  logic          done;
  logic          err_illegal;

  // Requester side: issues instructions and control, observes memory writes.
  modport master (
    output req_valid, req_op, req_cond, req_cmd, req_imm, req_s, req_load,
           req_rn, req_rd, req_imm24, seal, clear,
    input  req_ready, im_we, im_addr, im_wdata, word_count, done, err_illegal
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_op, req_cond, req_cmd, req_imm, req_s, req_load,
           req_rn, req_rd, req_imm24, seal, clear,
    output req_ready, im_we, im_addr, im_wdata, word_count, done, err_illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level instruction requests into 32-bit words
// {cond, op, funct, Rn, Rd, src} and streams them into instruction memory.
// A seal command appends a branch-to-self terminator and finishes the program.
// The one-entry output register doubles as the pending flag: pend_r is high
// exactly in the cycle its word is being written (im_we).
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  // Slots usable by requests; the final slot is kept for the terminator.
  localparam logic [CW:0] LAST_SLOT  = (CW + 1)'(DEPTH - 1);
  localparam logic [31:0] TERMINATOR = 32'hEAFF_FFFE;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SEAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          pend_r;
  logic [31:0]   im_addr_r;
  logic [31:0]   im_wdata_r;
  logic [CW-1:0] word_count_r;
  logic          done_r;
  logic          err_illegal_r;

  logic          ready_s;
  logic          accept_s;
  logic          legal_s;
  logic          illegal_s;
  logic          term_s;
  logic [CW:0]   used_s;
  logic [31:0]   slot_addr_s;

  // Data-processing: {cond, 00, I, cmd, S, Rn, Rd, src2}.
  function automatic logic [31:0] enc_dp(input logic [3:0] cond, input logic imm,
                                         input logic [3:0] cmd, input logic s,
                                         input logic [3:0] rn, input logic [3:0] rd,
                                         input logic [11:0] src);
    return {cond, 2'b00, imm, cmd, s, rn, rd, src};
  endfunction

  // Memory: funct = {~I, P=1, U=1, B=0, W=0, L}; an immediate request means a
  // register-free offset, hence the inverted I bit.
  function automatic logic [31:0] enc_mem(input logic [3:0] cond, input logic imm,
                                          input logic load, input logic [3:0] rn,
                                          input logic [3:0] rd, input logic [11:0] src);
    return {cond, 2'b01, ~imm, 1'b1, 1'b1, 1'b0, 1'b0, load, rn, rd, src};
  endfunction

  // Branch: {cond, 10, 10, imm24}.
  function automatic logic [31:0] enc_br(input logic [3:0] cond, input logic [23:0] imm24);
    return {cond, 2'b10, 2'b10, imm24};
  endfunction

  // Dispatch on op; op=11 never reaches the output register.
  function automatic logic [31:0] enc_word(input logic [1:0] op, input logic [3:0] cond,
                                           input logic [3:0] cmd, input logic imm,
                                           input logic s, input logic load,
                                           input logic [3:0] rn, input logic [3:0] rd,
                                           input logic [23:0] imm24);
    logic [31:0] w;
    case (op)
      2'b00:   w = enc_dp(cond, imm, cmd, s, rn, rd, imm24[11:0]);
      2'b01:   w = enc_mem(cond, imm, load, rn, rd, imm24[11:0]);
      2'b10:   w = enc_br(cond, imm24);
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Slots claimed so far (written plus in flight) and the byte address of the next one.
  always_comb begin
    used_s      = {1'b0, word_count_r} + {{CW{1'b0}}, pend_r};
    slot_addr_s = BASE_ADDR + ({{(31 - CW){1'b0}}, used_s} << 2);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: clear overrides everything; SEAL waits for the in-flight word to drain.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.clear) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.seal) begin
            state_nxt_s = ST_SEAL;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_SEAL: begin
          if (!pend_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SEAL;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_RUN;
      endcase
    end
  end

  // Handshake and write decisions for this cycle.
  always_comb begin
    ready_s   = 1'b0;
    accept_s  = 1'b0;
    legal_s   = 1'b0;
    illegal_s = 1'b0;
    term_s    = 1'b0;
    ready_s   = !rst && (state_r == ST_RUN) && !bus.seal && !bus.clear && (used_s < LAST_SLOT);
    accept_s  = bus.req_valid && ready_s;
    legal_s   = accept_s && (bus.req_op != 2'b11);
    illegal_s = accept_s && (bus.req_op == 2'b11);
    term_s    = !bus.clear && (state_r == ST_SEAL) && !pend_r;
  end

  // Output register, word counter and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r        <= 1'b0;
      im_addr_r     <= BASE_ADDR;
      im_wdata_r    <= 32'h0000_0000;
      word_count_r  <= {CW{1'b0}};
      done_r        <= 1'b0;
      err_illegal_r <= 1'b0;
    end else if (bus.clear) begin
      pend_r        <= 1'b0;
      word_count_r  <= {CW{1'b0}};
      done_r        <= 1'b0;
      err_illegal_r <= 1'b0;
    end else begin
      word_count_r  <= word_count_r + {{(CW - 1){1'b0}}, pend_r};
      done_r        <= (state_r == ST_DONE);
      err_illegal_r <= err_illegal_r | illegal_s;
      if (legal_s) begin
        pend_r     <= 1'b1;
        im_addr_r  <= slot_addr_s;
        im_wdata_r <= enc_word(bus.req_op, bus.req_cond, bus.req_cmd, bus.req_imm,
                               bus.req_s, bus.req_load, bus.req_rn, bus.req_rd,
                               bus.req_imm24);
      end else if (term_s) begin
        pend_r     <= 1'b1;
        im_addr_r  <= slot_addr_s;
        im_wdata_r <= TERMINATOR;
      end else begin
        pend_r <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.im_we       = pend_r;
  assign bus.im_addr     = im_addr_r;
  assign bus.im_wdata    = im_wdata_r;
  assign bus.word_count  = word_count_r;
  assign bus.done        = done_r;
  assign bus.err_illegal = err_illegal_r;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized stimulus against a program-level
// reference model; expected writes go into a queue that an independent
// monitor drains whenever the encoder strobes im_we.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] TERM  = 32'hEAFF_FFFE;

  logic clk = 1'b0;
  logic rst;

  instr_encoder_if #(.DEPTH(DEPTH)) bus ();

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];

  // Reference model: a program is a list of words; m_len counts claimed slots.
  bit m_open, m_sealing, m_sealed, m_inflight, m_err, m_done;
  int m_len, m_wc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [3:0] cond,
                                           input logic [3:0] cmd, input logic imm,
                                           input logic s, input logic ld,
                                           input logic [3:0] rn, input logic [3:0] rd,
                                           input logic [23:0] i24);
    logic [31:0] src;
    logic [31:0] w;
    src = 32'(i24) & 32'h0000_0FFF;
    w = (32'(cond) << 28) | (32'(rn) << 16) | (32'(rd) << 12);
    case (op)
      2'd0:    w = w | (32'(imm) << 25) | (32'(cmd) << 21) | (32'(s) << 20) | src;
      2'd1:    w = w | (32'd1 << 26) | (32'(!imm) << 25) | (32'd3 << 23) | (32'(ld) << 20) | src;
      default: w = (32'(cond) << 28) | (32'd10 << 24) | 32'(i24);
    endcase
    return w;
  endfunction

  task automatic model_clear();
    m_open = 1'b1; m_sealing = 1'b0; m_sealed = 1'b0; m_inflight = 1'b0;
    m_err = 1'b0; m_done = 1'b0; m_len = 0; m_wc = 0;
  endtask

  function automatic bit exp_ready();
    return !rst && m_open && !bus.seal && !bus.clear && (m_len < DEPTH - 1);
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_edge(input bit rdy);
    bit acc;
    bit ld_next;
    acc = bus.req_valid && rdy;
    if (bus.clear) begin
      model_clear();
    end else begin
      ld_next = 1'b0;
      m_done = m_sealed;
      m_wc += int'(m_inflight);
      if (acc && bus.req_op == 2'b11) begin
        m_err = 1'b1;
      end else if (acc) begin
        sb_q.push_back({BASE + 32'(4 * m_len),
                        ref_word(bus.req_op, bus.req_cond, bus.req_cmd, bus.req_imm, bus.req_s,
                                 bus.req_load, bus.req_rn, bus.req_rd, bus.req_imm24)});
        m_len++;
        ld_next = 1'b1;
      end else if (m_sealing && !m_inflight) begin
        sb_q.push_back({BASE + 32'(4 * m_len), TERM});
        m_len++;
        ld_next = 1'b1;
        m_sealing = 1'b0;
        m_sealed = 1'b1;
      end
      if (m_open && bus.seal) begin
        m_open = 1'b0;
        m_sealing = 1'b1;
      end
      m_inflight = ld_next;
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] cond,
                       input logic [3:0] cmd, input logic imm, input logic s, input logic ld,
                       input logic [3:0] rn, input logic [3:0] rd, input logic [23:0] i24,
                       input logic sl, input logic cl);
    bus.req_valid = v;   bus.req_op = op;   bus.req_cond = cond; bus.req_cmd = cmd;
    bus.req_imm = imm;   bus.req_s = s;     bus.req_load = ld;   bus.req_rn = rn;
    bus.req_rd = rd;     bus.req_imm24 = i24; bus.seal = sl;     bus.clear = cl;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b0);
  endtask

  // One clock cycle: check ready, take the edge, check status at the next falling edge.
  task automatic step();
    bit rdy;
    #1;
    rdy = exp_ready();
    check("req_ready", 32'(bus.req_ready), 32'(rdy));
    @(posedge clk);
    model_edge(rdy);
    @(negedge clk);
    check("word_count", 32'(bus.word_count), 32'(m_wc));
    check("done", 32'(bus.done), 32'(m_done));
    check("err_illegal", 32'(bus.err_illegal), 32'(m_err));
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && bus.im_we) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_write: got write addr %h data %h expected no write", bus.im_addr, bus.im_wdata);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_addr", bus.im_addr, e[63:32]);
        check("sb_data", bus.im_wdata, e[31:0]);
      end
    end
  end

  initial begin
    bit rdy;
    rst = 1'b1;
    idle();
    model_clear();
    #3;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_we", 32'(bus.im_we), 32'd0);
    check("rst_addr", bus.im_addr, BASE);
    check("rst_wdata", bus.im_wdata, 32'd0);
    check("rst_count", 32'(bus.word_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Illegal op: accepted, nothing written, sticky error.
    drive(1'b1, 2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 24'h0, 1'b0, 1'b0);
    step();
    check("illegal_no_we", 32'(bus.im_we), 32'd0);
    check("illegal_err", 32'(bus.err_illegal), 32'd1);

    // Fill: data-processing, memory, branch on consecutive edges.
    drive(1'b1, 2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 24'h000005, 1'b0, 1'b0);
    step();
    check("dp_we", 32'(bus.im_we), 32'd1);
    check("dp_addr", bus.im_addr, 32'h0000_0000);
    check("dp_data", bus.im_wdata, 32'hE282_1005);
    drive(1'b1, 2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 4'h3, 24'h000008, 1'b0, 1'b0);
    step();
    check("mem_addr", bus.im_addr, 32'h0000_0004);
    check("mem_data", bus.im_wdata, 32'hE594_3008);
    check("dp_count", 32'(bus.word_count), 32'd1);
    drive(1'b1, 2'b10, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h000010, 1'b0, 1'b0);
    step();
    check("br_addr", bus.im_addr, 32'h0000_0008);
    check("br_data", bus.im_wdata, 32'h0A00_0010);
    drive(1'b1, 2'b00, 4'hE, 4'h1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h1, 24'h000001, 1'b0, 1'b0);
    #1;
    check("full_ready", 32'(bus.req_ready), 32'd0);
    step();

    // Seal: terminator at the reserved slot, then done.
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b1, 1'b0);
    step();
    check("seal_wait_we", 32'(bus.im_we), 32'd0);
    idle();
    step();
    check("term_we", 32'(bus.im_we), 32'd1);
    check("term_addr", bus.im_addr, 32'h0000_000C);
    check("term_data", bus.im_wdata, 32'hEAFF_FFFE);
    step();
    check("sealed_done", 32'(bus.done), 32'd1);
    check("sealed_count", 32'(bus.word_count), 32'd4);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b1, 1'b0);
    step();
    check("done_seal_no_we", 32'(bus.im_we), 32'd0);

    // Clear, then seal alongside a request: the request is dropped.
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b1);
    step();
    check("clear_done", 32'(bus.done), 32'd0);
    drive(1'b1, 2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'h2, 4'h1, 24'h000005, 1'b1, 1'b0);
    step();
    check("seal_blocks_req", 32'(bus.im_we), 32'd0);
    idle();
    step();
    check("seal_only_term_addr", bus.im_addr, 32'h0000_0000);
    step();

    // Clear while a write is in flight.
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b1);
    step();
    drive(1'b1, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b00, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 4'h3, 4'h4, 24'h000ABC, 1'b0, 1'b0);
    step();
    check("pend_we", 32'(bus.im_we), 32'd1);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b1);
    step();
    check("clear_no_we", 32'(bus.im_we), 32'd0);
    check("clear_count", 32'(bus.word_count), 32'd0);
    check("clear_err", 32'(bus.err_illegal), 32'd0);

    // Asynchronous reset between edges with a write in flight.
    drive(1'b1, 2'b11, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b10, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h123456, 1'b0, 1'b0);
    step();
    drive(1'b1, 2'b01, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h6, 24'h000FFF, 1'b0, 1'b0);
    #1;
    rdy = exp_ready();
    @(posedge clk);
    model_edge(rdy);
    #2;
    rst = 1'b1;
    #1;
    check("arst_we", 32'(bus.im_we), 32'd0);
    check("arst_addr", bus.im_addr, BASE);
    check("arst_wdata", bus.im_wdata, 32'd0);
    check("arst_count", 32'(bus.word_count), 32'd0);
    check("arst_err", 32'(bus.err_illegal), 32'd0);
    check("arst_ready", 32'(bus.req_ready), 32'd0);
    sb_q.delete();
    model_clear();
    @(negedge clk);
    idle();
    #2;
    rst = 1'b0;
    step();

    // Randomized programs.
    for (int p = 0; p < 60; p++) begin
      drive(1'b0, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b0, 1'b1);
      step();
      for (int c = 0; c < int'($urandom_range(2, 10)); c++) begin
        logic [1:0] op;
        op = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        drive(1'($urandom_range(0, 3) != 0), op, 4'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
              24'($urandom), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0));
        step();
      end
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 2'b00, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0, 1'b1, 1'b0);
        step();
      end
      idle();
      for (int c = 0; c < 3; c++) begin
        step();
      end
    end

    idle();
    for (int c = 0; c < 3; c++) begin
      step();
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder for the filter GPU. It accepts field-level instruction requests over a valid/ready handshake and packs each one into the 32-bit word format consumed by `control_unit`. That format is cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], src[11:0]. It writes the words sequentially into instruction memory and, on command, seals the program with a branch-to-self terminator.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word.
- DEPTH, 64, capacity in words (≥2); the last slot is reserved for the terminator.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  encoder accepts a request this cycle.
- req_op  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
- req_cond  in  4  condition field.
- req_cmd  in  4  ALU cmd (data-processing only).
- req_imm  in  1  immediate source2/offset.
- req_s  in  1  set flags (data-processing only).
- req_load  in  1  1 = LDR, 0 = STR (memory only).
- req_rn, req_rd  in  4 each  register fields.
- req_imm24  in  24  branch offset; bits [11:0] are src2 for data-processing and memory.
- seal  in  1  append terminator and finish.
- clear  in  1  synchronous restart of the program.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  32  write address.
- im_wdata  out  32  encoded word.
- word_count  out  $clog2(DEPTH+1)  words written since reset or clear.
- done  out  1  program sealed.
- err_illegal  out  1  sticky: an op=11 request was accepted.

## Operation
- States: RUN, SEAL, DONE. Reset state is RUN.
- A handshake completes when req_valid && req_ready. Accepted legal requests are encoded into a one-entry output register, and pend is set.
- req_ready = (state==RUN) && !seal && !clear && (word_count + pend < DEPTH-1).
- Encoding:
  - Data-processing: {cond, 2'b00, imm, cmd, s, rn, rd, imm24[11:0]}.
  - Memory: {cond, 2'b01, ~imm, 1, 1, 0, 0, load, rn, rd, imm24[11:0]}.
  - Branch: {cond, 2'b10, 2'b10, imm24}.
- op=11 is still accepted (ready honoured) but nothing is written: err_illegal is set, pend is unchanged, and word_count is unchanged.
- Each write increments word_count. The write address is BASE_ADDR + 4*word_count at the time of the write.
- Seal, from RUN:
  - If seal is high, go to SEAL. A request in the same cycle is not accepted.
  - SEAL waits until pend==0, then writes 32'hEAFF_FFFE (B . , cond=AL) at the next address and goes to DONE.
- DONE: done=1, req_ready=0, seal ignored.
- clear has the highest priority in any state:
  - pend dropped; no write next cycle.
  - word_count=0, err_illegal=0, done=0, state RUN.
- Reset values: req_ready=0 during RST (1 after release), im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_count=0, done=0, err_illegal=0, pend=0.

## Timing
- Latency: a request accepted at edge N produces im_we=1 with its address and data during cycle N+1. im_addr and im_wdata are registered.
- Throughput: one request per cycle until the capacity bound makes req_ready fall.
- Terminator: written in the first cycle after entering SEAL in which pend==0. done rises on the following edge.
- Async RST mid-stream: outputs take their reset values immediately and any pending write is lost.

## Test plan
- Data-processing write:
  - Stimulus: op=00, cond=E, cmd=0100, imm=1, s=0, rn=2, rd=1, imm24=0x000005.
  - Response: next cycle im_we=1, im_addr=0x0, im_wdata=0xE2821005, then word_count=1.
- Memory write:
  - Stimulus: op=01, cond=E, load=1, imm=1, rn=4, rd=3, imm24=0x000008.
  - Response: im_wdata=0xE5943008.
- Branch write:
  - Stimulus: op=10, cond=0, imm24=0x000010.
  - Response: im_wdata=0x0A000010.
- Fill and seal (DEPTH=4, back-to-back valid):
  - Three requests are accepted on consecutive edges; writes go to addresses 0, 4, 8.
  - req_ready drops after the third acceptance.
  - Pulse seal: 0xEAFFFFFE is written at address 12, then done=1 and word_count=4.
- Illegal and priority:
  - op=11 request: accepted, no im_we, err_illegal=1, word_count unchanged.
  - seal together with req_valid: the request is not accepted.
  - seal in DONE: no write.
- Restart:
  - clear during a pending write: im_we stays 0 next cycle, word_count=0, state RUN, err_illegal=0.
  - Asynchronous RST between edges: all outputs reset immediately, without waiting for a CLK edge.
